// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
// Bundles every non-clock signal of the write-back arbiter.
//   pipe_*      : in-order result from the main pipeline (valid, rd, data, target file)
//   fpu_*       : out-of-order FPU result, valid/ready handshake (fpu_ready from arbiter)
//   rd_w, result_w, reg_write_w, fpu_reg_write_w : the shared register-file write port
//   stall_req   : asks upstream to hold pipe_* so a starved FIFO head can write
//   fifo_count  : number of FPU results currently queued
// The master modport is the producer side (pipeline, FPU and regfile),
// the slave modport is the arbiter itself.
interface writeback_arbiter_if #(
   parameter int DEPTH = 4,
   parameter int DATAW = 32
);
   logic                   pipe_valid;
   logic [4:0]             pipe_rd;
   logic [DATAW-1:0]       pipe_result;
   logic                   pipe_fpu;

   logic                   fpu_valid;
   logic                   fpu_ready;
   logic [4:0]             fpu_rd;
   logic [DATAW-1:0]       fpu_result;
   logic                   fpu_to_int;

   logic [4:0]             rd_w;
   logic [DATAW-1:0]       result_w;
   logic                   reg_write_w;
   logic                   fpu_reg_write_w;
   logic                   stall_req;
   logic [$clog2(DEPTH):0] fifo_count;

   modport master (
      output pipe_valid, pipe_rd, pipe_result, pipe_fpu,
      output fpu_valid, fpu_rd, fpu_result, fpu_to_int,
      input  fpu_ready,
      input  rd_w, result_w, reg_write_w, fpu_reg_write_w, stall_req, fifo_count
   );

   modport slave (
      input  pipe_valid, pipe_rd, pipe_result, pipe_fpu,
      input  fpu_valid, fpu_rd, fpu_result, fpu_to_int,
      output fpu_ready,
      output rd_w, result_w, reg_write_w, fpu_reg_write_w, stall_req, fifo_count
   );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Drives the single register-file write port from two sources: in-order
// pipeline results (priority) and out-of-order FPU results, which wait in a
// small FIFO. A saturating starvation counter raises stall_req so the FIFO
// head is guaranteed to write after STARVE_LIMIT cycles of waiting.
// Ports:
//   clk  : single clock, state updates on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : writeback_arbiter_if.slave (pipeline in, FPU handshake, write port,
//          stall_req, fifo_count)
module writeback_arbiter #(
   parameter int DEPTH        = 4,
   parameter int DATAW        = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                clk,
   input  logic                rst,
   writeback_arbiter_if.slave  bus
);
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam int SCW  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);
   localparam logic [SCW-1:0]  STARVE_MAX = SCW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_STARVED_HEAD,
      SRC_PIPE,
      SRC_HEAD,
      SRC_BYPASS
   } src_e;

   logic [DATAW-1:0] data_mem   [DEPTH];
   logic [4:0]       rd_mem     [DEPTH];
   logic             to_int_mem [DEPTH];

   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_ptr;
   logic [CNTW-1:0]  count;
   logic [SCW-1:0]   starve_cnt;

   src_e             src;
   logic             fifo_empty;
   logic             ready;
   logic             stall;
   logic             do_enq;
   logic             do_deq;
   logic             wr_any;
   logic             wr_fpu_target;
   logic [4:0]       wr_rd;
   logic [DATAW-1:0] wr_data;

   // Readiness only looks at occupancy, never at a same-cycle dequeue or at
   // fpu_valid, so the handshake has no combinational loop back to the FPU.
   assign fifo_empty = (count == '0);
   assign ready      = (count < FULL_COUNT);
   assign stall      = (starve_cnt == STARVE_MAX) && !fifo_empty;

   // Pick who owns the write port this cycle. A starved head beats the
   // pipeline; otherwise the pipeline wins, then the queued head, and only
   // with an empty queue may a fresh FPU result go straight through.
   always_comb begin
      src = SRC_NONE;
      if (stall)
         src = SRC_STARVED_HEAD;
      else if (bus.pipe_valid)
         src = SRC_PIPE;
      else if (!fifo_empty)
         src = SRC_HEAD;
      else if (bus.fpu_valid && ready)
         src = SRC_BYPASS;
   end

   // Mux the selected source onto the write port. An idle port drives zeros
   // so the regfile address/data lines are quiet and deterministic.
   always_comb begin
      wr_any        = 1'b0;
      wr_fpu_target = 1'b0;
      wr_rd         = '0;
      wr_data       = '0;
      case (src)
         SRC_STARVED_HEAD, SRC_HEAD: begin
            wr_any        = 1'b1;
            wr_fpu_target = !to_int_mem[rd_ptr];
            wr_rd         = rd_mem[rd_ptr];
            wr_data       = data_mem[rd_ptr];
         end
         SRC_PIPE: begin
            wr_any        = 1'b1;
            wr_fpu_target = bus.pipe_fpu;
            wr_rd         = bus.pipe_rd;
            wr_data       = bus.pipe_result;
         end
         SRC_BYPASS: begin
            wr_any        = 1'b1;
            wr_fpu_target = !bus.fpu_to_int;
            wr_rd         = bus.fpu_rd;
            wr_data       = bus.fpu_result;
         end
         default: begin
            wr_any = 1'b0;
         end
      endcase
   end

   // Integer x0 is hard-wired zero, so its write is dropped even though the
   // result still counts as consumed; f0 is a real register and is written.
   assign bus.rd_w            = wr_rd;
   assign bus.result_w        = wr_data;
   assign bus.reg_write_w     = wr_any && !wr_fpu_target && (wr_rd != 5'd0);
   assign bus.fpu_reg_write_w = wr_any && wr_fpu_target;
   assign bus.fpu_ready       = ready;
   assign bus.stall_req       = stall;
   assign bus.fifo_count      = count;

   assign do_deq = (src == SRC_STARVED_HEAD) || (src == SRC_HEAD);
   assign do_enq = bus.fpu_valid && ready && (src != SRC_BYPASS);

   // FIFO storage carries no reset: occupancy is tracked by count, so stale
   // entries are never observed.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         data_mem[wr_ptr]   <= bus.fpu_result;
         rd_mem[wr_ptr]     <= bus.fpu_rd;
         to_int_mem[wr_ptr] <= bus.fpu_to_int;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count moves
   // only when exactly one of enqueue/dequeue happens.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_deq)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_enq, do_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Counts how long the current head has been waiting. Any dequeue hands the
   // head role to a fresh entry, so the count restarts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (do_deq || fifo_empty) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
endmodule
